rf_scoreboard: RTL

RF_SCOREBOARD -- requirements
Module: rf_scoreboard

---
 rtl/rf_scoreboard_pkg.sv | 19 +
 rtl/rf_fwd_mux.sv | 36 +++
 rtl/rf_scoreboard.sv | 109 ++++++++++
 3 files changed

// File: rtl/rf_scoreboard_pkg.sv
// Shared constants and helpers for the register-file scoreboard.
package rf_scoreboard_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int DEPTH_DEF = 32;

  // Ceiling log2; clog2(1) = 0, clog2(32) = 5, clog2(33) = 6.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rf_fwd_mux.sv
// Per-read-port source selection: x0 forces zero, then same-cycle write
// forwarding (highest write port wins), otherwise the stored array value.
module rf_fwd_mux #(
  parameter int XLEN      = 32,
  parameter int AW        = 5,
  parameter int NUM_WR    = 2,
  parameter int BYPASS_EN = 0
) (
  input  logic [AW-1:0]          raddr,
  input  logic [XLEN-1:0]        arr_data,
  input  logic                   arr_busy,
  input  logic [NUM_WR-1:0]      wen,
  input  logic [NUM_WR*AW-1:0]   waddr,
  input  logic [NUM_WR*XLEN-1:0] wdata,
  output logic [XLEN-1:0]        rdata,
  output logic                   rbusy
);

  // Priority select; later assignments override earlier ones, so the
  // ascending loop lets the highest-indexed matching write port win.
  always_comb begin
    rdata = arr_data;
    rbusy = arr_busy;
    for (int j = 0; j < NUM_WR; j++) begin
      if ((BYPASS_EN != 0) && wen[j] && (waddr[j*AW +: AW] == raddr)) begin
        rdata = wdata[j*XLEN +: XLEN];
        rbusy = 1'b0;
      end
    end
    if (raddr == '0) begin
      rdata = '0;
      rbusy = 1'b0;
    end
  end

endmodule

// File: rtl/rf_scoreboard.sv
// Multi-port register file with a per-register "result pending" scoreboard.
// Reads are combinational, writes and busy updates commit on the rising edge.
module rf_scoreboard
  import rf_scoreboard_pkg::*;
#(
  parameter  int XLEN      = XLEN_DEF,
  parameter  int DEPTH     = DEPTH_DEF,
  parameter  int NUM_RD    = 2,
  parameter  int NUM_WR    = 2,
  parameter  int BYPASS_EN = 0,
  localparam int AW        = clog2(DEPTH),
  localparam int CW        = clog2(DEPTH + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_RD*AW-1:0]   i_raddr,
  output logic [NUM_RD*XLEN-1:0] o_rdata,
  output logic [NUM_RD-1:0]      o_rbusy,
  input  logic [NUM_WR-1:0]      i_wen,
  input  logic [NUM_WR*AW-1:0]   i_waddr,
  input  logic [NUM_WR*XLEN-1:0] i_wdata,
  input  logic                   i_issue_valid,
  input  logic [AW-1:0]          i_issue_addr,
  input  logic                   i_flush,
  output logic [CW-1:0]          o_busy_cnt
);

  logic [XLEN-1:0] regs_reg  [DEPTH];
  logic [XLEN-1:0] regs_next [DEPTH];
  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] busy_next;
  logic [CW-1:0]    cnt_reg;
  logic [CW-1:0]    cnt_next;

  // Write commit: ascending port loop so the highest-indexed port wins a
  // collision; x0 is never written.
  always_comb begin
    regs_next = regs_reg;
    for (int j = 0; j < NUM_WR; j++) begin
      if (i_wen[j] && (i_waddr[j*AW +: AW] != '0)) begin
        regs_next[i_waddr[j*AW +: AW]] = i_wdata[j*XLEN +: XLEN];
      end
    end
    regs_next[0] = '0;
  end

  // Busy update in priority order: write clears, issue sets, flush clears all.
  // The count is taken from the next vector so it is registered alongside it.
  always_comb begin
    busy_next = busy_reg;
    for (int j = 0; j < NUM_WR; j++) begin
      if (i_wen[j]) begin
        busy_next[i_waddr[j*AW +: AW]] = 1'b0;
      end
    end
    if (i_issue_valid && (i_issue_addr != '0)) begin
      busy_next[i_issue_addr] = 1'b1;
    end
    if (i_flush) begin
      busy_next = '0;
    end
    busy_next[0] = 1'b0;

    cnt_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_next = cnt_next + CW'(busy_next[i]);
    end
  end

  // State registers; reset discards contents and pending marks immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_reg[i] <= '0;
      end
      busy_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      regs_reg <= regs_next;
      busy_reg <= busy_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign o_busy_cnt = cnt_reg;

  // One forwarding mux per read port.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [AW-1:0] raddr;
    assign raddr = i_raddr[gi*AW +: AW];

    rf_fwd_mux #(
      .XLEN      (XLEN),
      .AW        (AW),
      .NUM_WR    (NUM_WR),
      .BYPASS_EN (BYPASS_EN)
    ) u_mux (
      .raddr    (raddr),
      .arr_data (regs_reg[raddr]),
      .arr_busy (busy_reg[raddr]),
      .wen      (i_wen),
      .waddr    (i_waddr),
      .wdata    (i_wdata),
      .rdata    (o_rdata[gi*XLEN +: XLEN]),
      .rbusy    (o_rbusy[gi])
    );
  end

endmodule
